// File: rtl/serial_cfg_loader.sv
// serial_cfg_loader
//   Multi-channel serial configuration loader for the DAC control path.
//   A frame is: start bit (1), AW address bits MSB first, W payload bits
//   MSB first, one even-parity bit covering address and payload. Bits are
//   taken only on clock edges where sen=1. A good frame to an existing
//   channel commits its payload to that channel's register; any other
//   frame is rejected and counted in a saturating error counter.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   sdi        serial data in
//   sen        bit strobe, sdi sampled only when sen=1
//   abort      drops the frame in progress without committing
//   clr_err    clears err_cnt (wins over a coincident rejection)
//   cfg_out    NCH*W channel registers, channel k at [k*W +: W]
//   loaded     per-channel sticky "written since reset" flag
//   busy       frame in progress (combinational from state)
//   done       one-cycle pulse after a successful commit
//   frame_err  one-cycle pulse after a rejected frame
//   err_cnt    saturating count of rejected frames
module serial_cfg_loader #(
   parameter int          NCH     = 3,
   parameter int          W       = 8,
   parameter int unsigned RST_VAL = 0,
   parameter int          ECW     = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sdi,
   input  logic               sen,
   input  logic               abort,
   input  logic               clr_err,
   output logic [NCH*W-1:0]   cfg_out,
   output logic [NCH-1:0]     loaded,
   output logic               busy,
   output logic               done,
   output logic               frame_err,
   output logic [ECW-1:0]     err_cnt
);

   localparam int AW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int SW = AW + W;
   localparam int CMAX = (W > AW) ? W : AW;
   localparam int CW = $clog2(CMAX + 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, PAR} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [SW-1:0]      sh_q, sh_d;
   logic [NCH*W-1:0]   cfg_q, cfg_d;
   logic [NCH-1:0]     loaded_q, loaded_d;
   logic               done_q, done_d;
   logic               ferr_q, ferr_d;
   logic [ECW-1:0]     err_q, err_d;

   logic [AW-1:0]      addr_w;
   logic [W-1:0]       payload_w;
   logic               par_ok_w;
   logic               addr_ok_w;

   function automatic logic [ECW-1:0] sat_inc(input logic [ECW-1:0] v);
      return (v == {ECW{1'b1}}) ? v : v + ECW'(1);
   endfunction

   function automatic logic [NCH*W-1:0] rst_image();
      logic [NCH*W-1:0] r;
      for (int k = 0; k < NCH; k++) begin
         r[k*W +: W] = W'(RST_VAL);
      end
      return r;
   endfunction

   // Address occupies the upper AW bits of the shift register once the
   // payload has been shifted in behind it.
   assign addr_w    = sh_q[SW-1 -: AW];
   assign payload_w = sh_q[W-1:0];
   assign par_ok_w  = ~(^sh_q ^ sdi);
   assign addr_ok_w = (int'(addr_w) < NCH);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sh_d     = sh_q;
      cfg_d    = cfg_q;
      loaded_d = loaded_q;
      done_d   = 1'b0;
      ferr_d   = 1'b0;
      err_d    = err_q;

      if (abort) begin
         // Abort beats everything, including a coincident parity edge.
         state_d = IDLE;
      end else if (sen) begin
         case (state_q)
            IDLE: begin
               if (sdi) begin
                  state_d = ADDR;
                  cnt_d   = '0;
                  sh_d    = '0;
               end
            end
            ADDR: begin
               sh_d = {sh_q[SW-2:0], sdi};
               if (cnt_q == CW'(AW - 1)) begin
                  state_d = DATA;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            DATA: begin
               sh_d = {sh_q[SW-2:0], sdi};
               if (cnt_q == CW'(W - 1)) begin
                  state_d = PAR;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            PAR: begin
               state_d = IDLE;
               if (par_ok_w && addr_ok_w) begin
                  for (int k = 0; k < NCH; k++) begin
                     if (int'(addr_w) == k) begin
                        cfg_d[k*W +: W] = payload_w;
                        loaded_d[k]     = 1'b1;
                     end
                  end
                  done_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
                  err_d  = sat_inc(err_q);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (clr_err) begin
         err_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sh_q     <= '0;
         cfg_q    <= rst_image();
         loaded_q <= '0;
         done_q   <= 1'b0;
         ferr_q   <= 1'b0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sh_q     <= sh_d;
         cfg_q    <= cfg_d;
         loaded_q <= loaded_d;
         done_q   <= done_d;
         ferr_q   <= ferr_d;
         err_q    <= err_d;
      end
   end

   assign cfg_out   = cfg_q;
   assign loaded    = loaded_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign frame_err = ferr_q;
   assign err_cnt   = err_q;

endmodule

// File: tb/tb_serial_cfg_loader.sv
module tb_serial_cfg_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sdi = 1'b0;
   logic        sen = 1'b0;
   logic        abort = 1'b0;
   logic        clr_err = 1'b0;
   logic [23:0] cfg_out;
   logic [2:0]  loaded;
   logic        busy;
   logic        done;
   logic        frame_err;
   logic [3:0]  err_cnt;

   int total = 0;
   int bad = 0;

   serial_cfg_loader #(.NCH(3), .W(8), .RST_VAL(0), .ECW(4)) dut (
      .clk(clk), .rst(rst), .sdi(sdi), .sen(sen), .abort(abort),
      .clr_err(clr_err), .cfg_out(cfg_out), .loaded(loaded), .busy(busy),
      .done(done), .frame_err(frame_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One strobe: drive sdi with sen=1 for exactly one edge.
   task automatic strobe(input logic b, input logic ab, input logic clr);
      sdi = b; sen = 1'b1; abort = ab; clr_err = clr;
      tick();
      sen = 1'b0; sdi = 1'b0; abort = 1'b0; clr_err = 1'b0;
   endtask

   // Full frame; gap = sen-low cycles (with sdi noise) between strobes.
   // Returns one cycle after the parity edge.
   task automatic frame(input logic [1:0] a, input logic [7:0] d, input logic p,
                        input int gap, input logic ab_par, input logic clr_par);
      logic [11:0] bits;
      bits = {1'b1, a, d, p};
      for (int i = 11; i >= 0; i--) begin
         if (i != 11) begin
            for (int g = 0; g < gap; g++) begin
               sdi = 1'($urandom_range(0, 1));
               tick();
            end
         end
         strobe(bits[i], (i == 0) ? ab_par : 1'b0, (i == 0) ? clr_par : 1'b0);
      end
   endtask

   initial begin
      logic [11:0] pb;

      // Reset
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      check("rst_cfg", 32'(cfg_out), 32'h0);
      check("rst_loaded", 32'(loaded), 32'h0);
      check("rst_err", 32'(err_cnt), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_ferr", 32'(frame_err), 32'h0);

      // Good frame: addr 1, data A5, par 1
      frame(2'b01, 8'hA5, 1'b1, 0, 1'b0, 1'b0);
      check("g1_cfg", 32'(cfg_out), 32'h00A500);
      check("g1_loaded", 32'(loaded), 32'h2);
      check("g1_done", 32'(done), 32'h1);
      check("g1_ferr", 32'(frame_err), 32'h0);
      check("g1_err", 32'(err_cnt), 32'h0);
      check("g1_busy", 32'(busy), 32'h0);
      tick();
      check("g1_done_drop", 32'(done), 32'h0);

      // Bad parity
      frame(2'b01, 8'hA5, 1'b0, 0, 1'b0, 1'b0);
      check("bp_ferr", 32'(frame_err), 32'h1);
      check("bp_done", 32'(done), 32'h0);
      check("bp_err", 32'(err_cnt), 32'h1);
      check("bp_cfg", 32'(cfg_out), 32'h00A500);
      check("bp_loaded", 32'(loaded), 32'h2);
      tick();
      check("bp_ferr_drop", 32'(frame_err), 32'h0);

      // Clear, then out-of-range address with correct parity
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      check("clr1_err", 32'(err_cnt), 32'h0);
      frame(2'b11, 8'h3C, 1'b0, 0, 1'b0, 1'b0);
      check("oor_ferr", 32'(frame_err), 32'h1);
      check("oor_err", 32'(err_cnt), 32'h1);
      check("oor_cfg", 32'(cfg_out), 32'h00A500);
      check("oor_loaded", 32'(loaded), 32'h2);
      for (int n = 0; n < 15; n++) frame(2'b11, 8'h3C, 1'b0, 0, 1'b0, 1'b0);
      check("sat_err", 32'(err_cnt), 32'hF);
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      check("clr2_err", 32'(err_cnt), 32'h0);

      // Rejection coinciding with clr_err: clear wins, frame_err still pulses
      frame(2'b11, 8'h3C, 1'b0, 0, 1'b0, 1'b1);
      check("clrrej_ferr", 32'(frame_err), 32'h1);
      check("clrrej_err", 32'(err_cnt), 32'h0);

      // Slow strobes (every 3rd cycle) with sdi noise: addr 0, data FF, par 0
      pb = {1'b1, 2'b00, 8'hFF, 1'b0};
      strobe(pb[11], 1'b0, 1'b0);
      check("slow_busy_start", 32'(busy), 32'h1);
      for (int i = 10; i >= 0; i--) begin
         for (int g = 0; g < 2; g++) begin
            sdi = 1'($urandom_range(0, 1));
            tick();
            check("slow_busy_hold", 32'(busy), 32'h1);
         end
         strobe(pb[i], 1'b0, 1'b0);
      end
      check("slow_cfg", 32'(cfg_out), 32'h00A5FF);
      check("slow_loaded", 32'(loaded), 32'h3);
      check("slow_done", 32'(done), 32'h1);
      check("slow_busy_end", 32'(busy), 32'h0);

      // Abort after 5 data bits of a frame to addr 2
      pb = {1'b1, 2'b10, 8'h77, 1'b0};
      for (int i = 11; i >= 4; i--) strobe(pb[i], 1'b0, 1'b0);
      check("ab_busy_pre", 32'(busy), 32'h1);
      abort = 1'b1; tick(); abort = 1'b0;
      check("ab_busy", 32'(busy), 32'h0);
      check("ab_cfg", 32'(cfg_out), 32'h00A5FF);
      check("ab_done", 32'(done), 32'h0);
      check("ab_ferr", 32'(frame_err), 32'h0);

      // Abort on the parity edge: nothing committed
      frame(2'b01, 8'h55, 1'b1, 0, 1'b1, 1'b0);
      check("abp_cfg", 32'(cfg_out), 32'h00A5FF);
      check("abp_done", 32'(done), 32'h0);
      check("abp_ferr", 32'(frame_err), 32'h0);
      check("abp_busy", 32'(busy), 32'h0);

      // Reset mid-frame
      for (int i = 11; i >= 6; i--) strobe(pb[i], 1'b0, 1'b0);
      check("rm_busy_pre", 32'(busy), 32'h1);
      rst = 1'b1; sen = 1'b1; sdi = 1'b1; tick(); rst = 1'b0; sen = 1'b0; sdi = 1'b0;
      check("rm_busy", 32'(busy), 32'h0);
      check("rm_cfg", 32'(cfg_out), 32'h0);
      check("rm_loaded", 32'(loaded), 32'h0);
      check("rm_done", 32'(done), 32'h0);

      // Back-to-back frames, no idle strobe between
      frame(2'b00, 8'h12, 1'b0, 0, 1'b0, 1'b0);
      check("bb1_done", 32'(done), 32'h1);
      check("bb1_cfg", 32'(cfg_out), 32'h000012);
      frame(2'b10, 8'h34, 1'b0, 0, 1'b0, 1'b0);
      check("bb2_done", 32'(done), 32'h1);
      check("bb2_cfg", 32'(cfg_out), 32'h340012);
      check("bb2_loaded", 32'(loaded), 32'h5);

      // Same value again still pulses done
      frame(2'b10, 8'h34, 1'b0, 0, 1'b0, 1'b0);
      check("rep_done", 32'(done), 32'h1);
      check("rep_cfg", 32'(cfg_out), 32'h340012);
      tick();
      check("rep_done_drop", 32'(done), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
